flash_scheduler: RTL and testbench
==================================

// Module: flash_scheduler
// PURPOSE
//   Owns the four colour LEDs and generates flash timing for the game FSM.
//   Arbitrates three requesters for the LEDs: sequence playback (PLAY), player-input echo (ECHO) and fail flash (FAIL).
//   Derives ON/gap durations from the current speed level and emits the one-cycle pulse tick consumed by the game FSM.
// PARAMETERS
//   BASE_TICKS  25_000_000  ON duration in clk cycles at speed 0 (500 ms at 50 MHz)
//   STEP_TICKS  3_000_000   ON reduction per speed level
//   MIN_TICKS   5_000_000   floor for ON duration
//   SPEED_W     3           width of speed input
//   TONE_BASE   25_000      buzzer half-period for colour 0 (FLASH_BUZZER_EN only)
// PORTS
//   clk          in   1        system clock
//   reset        in   1        reset
//   speed        in   SPEED_W  speed level; sampled at PLAY grant
//   play_req     in   1        level request, one flash of play_colour
//   play_colour  in   2        colour index, captured at grant
//   play_gnt     out  1        1-cycle grant strobe
//   play_done    out  1        1-cycle strobe at end of gap
//   echo_req     in   1        level; LED lit while held
//   echo_colour  in   2        colour index, captured at grant
//   echo_gnt     out  1        high throughout ECHO
//   fail_req     in   1        level request, triple flash of fail_colour
//   fail_colour  in   2        colour index, captured at grant
//   fail_done    out  1        1-cycle strobe after third flash
//   led          out  4        one-hot LED drive, bit = colour index
//   pulse        out  1        1-cycle tick at end of every timed ON or gap phase
//   busy         out  1        high in any state except IDLE
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Reset asserted (reset=0), including mid-flash, forces immediately:
//     - state IDLE, all outputs 0, counters 0
//     - no done strobe is issued for an aborted request
//   - States: IDLE, PLAY_ON, PLAY_GAP, ECHO, FAIL_ON, FAIL_OFF.
//   - Arbitration, evaluated in IDLE only, fixed priority FAIL > PLAY > ECHO; no preemption.
//   - Grant at edge k: next state entered at k; colour (and speed for PLAY) captured; play_gnt high for the cycle after k.
//   - on_t = max(BASE_TICKS - speed*STEP_TICKS, MIN_TICKS):
//     - computed signed/wide, so underflow clamps to MIN_TICKS
//     - gap_t = on_t >> 1
//     - counter 26 bits
//   - PLAY_ON: led lit on_t cycles, pulse on last cycle -> PLAY_GAP.
//   - PLAY_GAP: led 0 gap_t cycles, pulse and play_done on last cycle -> IDLE.
//   - FAIL: FAIL_ON/FAIL_OFF pairs, always at speed-0 timing (BASE_TICKS, BASE_TICKS>>1):
//     - 2-bit flash counter
//     - after third FAIL_OFF: fail_done -> IDLE
//   - ECHO: led lit, echo_gnt high; exit to IDLE the cycle after echo_req=0; untimed, no pulse.
//   - A req still high in IDLE after its done strobe is granted again (one more flash); requesters drop req on done.
//   - Colour or speed changes after grant are ignored until the next grant.
//   - led is exactly one-hot in lit phases, 0 otherwise.
//   - busy=0 only in IDLE.
// CONFIGURATION
//   - FLASH_BUZZER_EN defined: adds output tone (1 bit, reset 0).
//     - Square wave with half-period TONE_BASE << colour, active during PLAY_ON, ECHO and FAIL_ON.
//     - Tone divider restarts at each lit-phase entry; tone is 0 otherwise.
//   - FLASH_BUZZER_EN undefined: no tone port, no divider logic.
// TESTING (BASE_TICKS=20, STEP_TICKS=4, MIN_TICKS=6, TONE_BASE=2)
//   1. play_req=1, play_colour=2, speed=0:
//      - play_gnt 1 cycle; led=4'b0100 for 20 cycles, then 0 for 10
//      - pulse at cycle 20 and cycle 30; play_done with second pulse
//   2. speed=5 (20-20 -> clamp): led lit 6 cycles, gap 3 cycles.
//   3. fail_req, play_req, echo_req raised together:
//      - fail wins: three 20/10 flashes of fail_colour, then fail_done
//      - PLAY granted next, then ECHO
//   4. echo_req held 7 cycles, echo_colour=0:
//      - led=4'b0001 and echo_gnt high while held
//      - both 0 one cycle after drop; no pulse
//   5. reset=0 at cycle 8 of PLAY_ON: led, busy, pulse 0 immediately; no play_done; IDLE after release.
//   6. FLASH_BUZZER_EN, colour 1, speed 0: tone toggles every 4 cycles during the 20 ON cycles; 0 throughout gap.

Source files
------------

// File: rtl/flash_scheduler.sv
// flash_scheduler: arbitrates PLAY/ECHO/FAIL requesters for the four colour LEDs and times each flash.
// Defining FLASH_BUZZER_EN adds the square-wave tone output and its divider.
module flash_scheduler #(
    parameter int unsigned BASE_TICKS = 25_000_000,
    parameter int unsigned STEP_TICKS = 3_000_000,
    parameter int unsigned MIN_TICKS  = 5_000_000,
    parameter int unsigned SPEED_W    = 3
`ifdef FLASH_BUZZER_EN
    ,
    parameter int unsigned TONE_BASE  = 25_000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               play_req,
    input  logic [1:0]         play_colour,
    output logic               play_gnt,
    output logic               play_done,
    input  logic               echo_req,
    input  logic [1:0]         echo_colour,
    output logic               echo_gnt,
    input  logic               fail_req,
    input  logic [1:0]         fail_colour,
    output logic               fail_done,
    output logic [3:0]         led,
    output logic               pulse,
    output logic               busy
`ifdef FLASH_BUZZER_EN
    ,
    output logic               tone
`endif
);

    localparam int unsigned CNT_W = 26;
    localparam logic [CNT_W-1:0] FAIL_ON_LOAD  = CNT_W'(BASE_TICKS - 1);
    localparam logic [CNT_W-1:0] FAIL_OFF_LOAD = CNT_W'((BASE_TICKS >> 1) - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY_ON  = 3'd1,
        S_PLAY_GAP = 3'd2,
        S_ECHO     = 3'd3,
        S_FAIL_ON  = 3'd4,
        S_FAIL_OFF = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         flash_q, flash_d;
    logic [1:0]         colour_q, colour_d;
    logic [SPEED_W-1:0] speed_q, speed_d;

    logic       lit_c, timed_c;
    logic [3:0] led_d;
    logic       pulse_d, play_gnt_d, play_done_d, echo_gnt_d, fail_done_d, busy_d;

    // ON duration in signed wide arithmetic so a large speed clamps instead of wrapping
    function automatic logic [CNT_W-1:0] on_ticks(input logic [SPEED_W-1:0] s);
        longint t;
        t = longint'(BASE_TICKS) - longint'(s) * longint'(STEP_TICKS);
        if (t < longint'(MIN_TICKS)) begin
            t = longint'(MIN_TICKS);
        end
        return CNT_W'(t);
    endfunction

`ifdef FLASH_BUZZER_EN
    localparam int unsigned TONE_W = $clog2(TONE_BASE * 8) + 1;
    logic [TONE_W-1:0] tone_div_q, tone_div_d, tone_half_c;
    logic              tone_d;
`endif

    // State register, datapath captures and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            flash_q   <= '0;
            colour_q  <= '0;
            speed_q   <= '0;
            led       <= '0;
            pulse     <= 1'b0;
            play_gnt  <= 1'b0;
            play_done <= 1'b0;
            echo_gnt  <= 1'b0;
            fail_done <= 1'b0;
            busy      <= 1'b0;
`ifdef FLASH_BUZZER_EN
            tone       <= 1'b0;
            tone_div_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flash_q   <= flash_d;
            colour_q  <= colour_d;
            speed_q   <= speed_d;
            led       <= led_d;
            pulse     <= pulse_d;
            play_gnt  <= play_gnt_d;
            play_done <= play_done_d;
            echo_gnt  <= echo_gnt_d;
            fail_done <= fail_done_d;
            busy      <= busy_d;
`ifdef FLASH_BUZZER_EN
            tone       <= tone_d;
            tone_div_q <= tone_div_d;
`endif
        end
    end

    // Next state: fixed-priority grant from IDLE, then down-counted phases
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flash_d  = flash_q;
        colour_d = colour_q;
        speed_d  = speed_q;
        case (state_q)
            S_IDLE: begin
                if (fail_req) begin
                    state_d  = S_FAIL_ON;
                    colour_d = fail_colour;
                    flash_d  = '0;
                    cnt_d    = FAIL_ON_LOAD;
                end else if (play_req) begin
                    state_d  = S_PLAY_ON;
                    colour_d = play_colour;
                    speed_d  = speed;
                    cnt_d    = on_ticks(speed) - CNT_W'(1);
                end else if (echo_req) begin
                    state_d  = S_ECHO;
                    colour_d = echo_colour;
                    cnt_d    = '0;
                end
            end
            S_PLAY_ON: begin
                if (cnt_q == '0) begin
                    state_d = S_PLAY_GAP;
                    cnt_d   = (on_ticks(speed_q) >> 1) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PLAY_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ECHO: begin
                if (!echo_req) begin
                    state_d = S_IDLE;
                end
            end
            S_FAIL_ON: begin
                if (cnt_q == '0) begin
                    state_d = S_FAIL_OFF;
                    cnt_d   = FAIL_OFF_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FAIL_OFF: begin
                if (cnt_q == '0) begin
                    if (flash_q == 2'd2) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FAIL_ON;
                        flash_d = flash_q + 2'd1;
                        cnt_d   = FAIL_ON_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        led_d       = '0;
        lit_c       = (state_d == S_PLAY_ON) || (state_d == S_ECHO) || (state_d == S_FAIL_ON);
        timed_c     = (state_d == S_PLAY_ON) || (state_d == S_PLAY_GAP) ||
                      (state_d == S_FAIL_ON) || (state_d == S_FAIL_OFF);
        if (lit_c) begin
            led_d = 4'b0001 << colour_d;
        end
        pulse_d     = timed_c && (cnt_d == '0);
        play_gnt_d  = (state_q == S_IDLE) && (state_d == S_PLAY_ON);
        play_done_d = (state_d == S_PLAY_GAP) && (cnt_d == '0);
        echo_gnt_d  = (state_d == S_ECHO);
        fail_done_d = (state_d == S_FAIL_OFF) && (cnt_d == '0) && (flash_d == 2'd2);
        busy_d      = (state_d != S_IDLE);
`ifdef FLASH_BUZZER_EN
        // Tone starts high on every lit-phase entry, then toggles each half-period
        tone_half_c = TONE_W'(TONE_BASE) << colour_d;
        tone_d      = 1'b0;
        tone_div_d  = '0;
        if (lit_c) begin
            if (state_d != state_q) begin
                tone_d     = 1'b1;
                tone_div_d = tone_half_c - TONE_W'(1);
            end else if (tone_div_q == '0) begin
                tone_d     = ~tone;
                tone_div_d = tone_half_c - TONE_W'(1);
            end else begin
                tone_d     = tone;
                tone_div_d = tone_div_q - TONE_W'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_flash_scheduler.sv
// tb_flash_scheduler: directed scenarios plus randomized traffic checked against a phase-list model.
// Tone checks are active when FLASH_BUZZER_EN is defined.
module tb_flash_scheduler;

    localparam int BASE = 20;
    localparam int STEP = 4;
    localparam int MINT = 6;
    localparam int TONE_BASE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] speed = '0;
    logic       play_req = 1'b0;
    logic [1:0] play_colour = '0;
    logic       play_gnt, play_done;
    logic       echo_req = 1'b0;
    logic [1:0] echo_colour = '0;
    logic       echo_gnt;
    logic       fail_req = 1'b0;
    logic [1:0] fail_colour = '0;
    logic       fail_done;
    logic [3:0] led;
    logic       pulse, busy;
`ifdef FLASH_BUZZER_EN
    logic       tone;
`endif

    flash_scheduler #(
        .BASE_TICKS(BASE), .STEP_TICKS(STEP), .MIN_TICKS(MINT), .SPEED_W(3)
`ifdef FLASH_BUZZER_EN
        , .TONE_BASE(TONE_BASE)
`endif
    ) dut (
        .clk(clk), .reset(reset), .speed(speed),
        .play_req(play_req), .play_colour(play_colour), .play_gnt(play_gnt), .play_done(play_done),
        .echo_req(echo_req), .echo_colour(echo_colour), .echo_gnt(echo_gnt),
        .fail_req(fail_req), .fail_colour(fail_colour), .fail_done(fail_done),
        .led(led), .pulse(pulse), .busy(busy)
`ifdef FLASH_BUZZER_EN
        , .tone(tone)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Model: a grant expands into a list of timed phases; echo is an untimed mode
    typedef struct {
        logic [1:0] colour;
        bit         lit;
        int         len;
        bit         play_end;
        bit         fail_end;
    } phase_t;

    phase_t     ph_q[$];
    phase_t     cur;
    bit         cur_valid;
    int         rem;
    bit         echo_on;
    logic [1:0] echo_col;
    logic [3:0] e_led;
    bit         e_pulse, e_pgnt, e_pdone, e_egnt, e_fdone, e_busy, m_lit;
`ifdef FLASH_BUZZER_EN
    bit         e_tone;
    int         tone_cnt;
    logic [3:0] prev_led;
`endif

    function automatic int on_time(input int s);
        int t;
        t = BASE - s * STEP;
        return (t < MINT) ? MINT : t;
    endfunction

    function automatic phase_t mk(input logic [1:0] c, input bit lit, input int len,
                                  input bit pe, input bit fe);
        phase_t p;
        p.colour = c; p.lit = lit; p.len = len; p.play_end = pe; p.fail_end = fe;
        return p;
    endfunction

    task automatic model_reset();
        ph_q.delete();
        cur_valid = 0; rem = 0; echo_on = 0; echo_col = '0;
        e_led = '0; e_pulse = 0; e_pgnt = 0; e_pdone = 0; e_egnt = 0; e_fdone = 0; e_busy = 0; m_lit = 0;
`ifdef FLASH_BUZZER_EN
        e_tone = 0; tone_cnt = 0; prev_led = '0;
`endif
    endtask

    // Advance the model across one clock edge using the inputs about to be sampled
    task automatic model_edge();
        e_pgnt = 0;
        if (echo_on) begin
            if (!echo_req) echo_on = 0;
        end else if (cur_valid) begin
            rem--;
            if (rem == 0) begin
                if (ph_q.size() > 0) begin
                    cur = ph_q.pop_front();
                    rem = cur.len;
                end else begin
                    cur_valid = 0;
                end
            end
        end else begin
            if (fail_req) begin
                for (int i = 0; i < 3; i++) begin
                    ph_q.push_back(mk(fail_colour, 1, BASE, 0, 0));
                    ph_q.push_back(mk(fail_colour, 0, BASE / 2, 0, i == 2));
                end
            end else if (play_req) begin
                ph_q.push_back(mk(play_colour, 1, on_time(int'(speed)), 0, 0));
                ph_q.push_back(mk(play_colour, 0, on_time(int'(speed)) / 2, 1, 0));
                e_pgnt = 1;
            end else if (echo_req) begin
                echo_on  = 1;
                echo_col = echo_colour;
            end
            if (ph_q.size() > 0) begin
                cur = ph_q.pop_front();
                rem = cur.len;
                cur_valid = 1;
            end
        end
        e_led = '0; e_pulse = 0; e_pdone = 0; e_fdone = 0; e_egnt = 0; e_busy = 0; m_lit = 0;
        if (echo_on) begin
            e_led = 4'b0001 << echo_col; e_egnt = 1; e_busy = 1; m_lit = 1;
        end else if (cur_valid) begin
            e_busy = 1;
            m_lit  = cur.lit;
            if (cur.lit) e_led = 4'b0001 << cur.colour;
            if (rem == 1) begin
                e_pulse = 1; e_pdone = cur.play_end; e_fdone = cur.fail_end;
            end
        end
`ifdef FLASH_BUZZER_EN
        // Every lit phase follows a dark cycle, so a dark-to-lit step marks a restart
        if (!m_lit) begin
            e_tone = 0; tone_cnt = 0;
        end else if (prev_led == 4'd0) begin
            e_tone = 1; tone_cnt = 1;
        end else if (tone_cnt == (TONE_BASE << (echo_on ? echo_col : cur.colour))) begin
            e_tone = !e_tone; tone_cnt = 1;
        end else begin
            tone_cnt++;
        end
        prev_led = e_led;
`endif
    endtask

    task automatic check_all();
        chk("led", 32'(led), 32'(e_led));
        chk("pulse", 32'(pulse), 32'(e_pulse));
        chk("play_gnt", 32'(play_gnt), 32'(e_pgnt));
        chk("play_done", 32'(play_done), 32'(e_pdone));
        chk("echo_gnt", 32'(echo_gnt), 32'(e_egnt));
        chk("fail_done", 32'(fail_done), 32'(e_fdone));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("led_onehot", 32'($onehot(led)), 32'(m_lit));
`ifdef FLASH_BUZZER_EN
        chk("tone", 32'(tone), 32'(e_tone));
`endif
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    int cyc, gnt_cyc, p1, p2, lit_cnt, pulse_cnt, egnt_cnt, pd_cnt, fd_cnt, echo_hold, echo_seen;

    task automatic clear_counts();
        cyc = 0; gnt_cyc = 0; p1 = 0; p2 = 0; lit_cnt = 0; pulse_cnt = 0;
        egnt_cnt = 0; pd_cnt = 0; fd_cnt = 0; echo_seen = 0;
    endtask

    // Run n cycles; requesters drop on their done strobe, echo drops after echo_hold cycles
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc++;
            if (play_gnt) gnt_cyc = cyc;
            if (led != 4'd0) lit_cnt++;
            if (pulse) begin
                if (pulse_cnt == 0) p1 = cyc;
                else if (pulse_cnt == 1) p2 = cyc;
                pulse_cnt++;
            end
            if (echo_gnt) egnt_cnt++;
            if (play_done) pd_cnt++;
            if (fail_done) fd_cnt++;
            if (e_pdone) play_req = 1'b0;
            if (e_fdone) fail_req = 1'b0;
            if (e_egnt) begin
                echo_seen++;
                if (echo_seen >= echo_hold) echo_req = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        echo_hold = 7;
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;

        // Single play flash at speed 0
        clear_counts();
        play_req = 1'b1; play_colour = 2'd2; speed = 3'd0;
        run(35);
        chk("t1_lit_cycles", 32'(lit_cnt), 32'd20);
        chk("t1_pulses", 32'(pulse_cnt), 32'd2);
        chk("t1_pulse_on_end", 32'(p1 - gnt_cyc), 32'd19);
        chk("t1_pulse_gap_end", 32'(p2 - gnt_cyc), 32'd29);
        chk("t1_play_done", 32'(pd_cnt), 32'd1);

        // Clamped duration at speed 5
        clear_counts();
        play_req = 1'b1; play_colour = 2'd1; speed = 3'd5;
        run(12);
        speed = 3'd0;
        chk("t2_lit_cycles", 32'(lit_cnt), 32'd6);
        chk("t2_gap_len", 32'(p2 - p1), 32'd3);

        // All three requesters at once
        clear_counts();
        echo_hold = 5;
        fail_req = 1'b1; fail_colour = 2'd3;
        play_req = 1'b1; play_colour = 2'd1;
        echo_req = 1'b1; echo_colour = 2'd2;
        run(140);
        chk("t3_fail_done", 32'(fd_cnt), 32'd1);
        chk("t3_play_done", 32'(pd_cnt), 32'd1);
        chk("t3_echo_cycles", 32'(egnt_cnt), 32'd5);
        chk("t3_pulses", 32'(pulse_cnt), 32'd8);

        // Echo held for seven cycles
        clear_counts();
        echo_hold = 7;
        echo_req = 1'b1; echo_colour = 2'd0;
        run(12);
        chk("t4_echo_cycles", 32'(egnt_cnt), 32'd7);
        chk("t4_pulses", 32'(pulse_cnt), 32'd0);

        // Asynchronous reset in the middle of a flash
        clear_counts();
        play_req = 1'b1; play_colour = 2'd1; speed = 3'd0;
        run(8);
        #2 reset = 1'b0;
        play_req = 1'b0;
        #1;
        chk("t5_led", 32'(led), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_pulse", 32'(pulse), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        run(40);
        chk("t5_no_done", 32'(pd_cnt), 32'd0);

        // Randomized traffic
        echo_hold = 1 << 30;
        for (int c = 0; c < 3000; c++) begin
            speed       = 3'($urandom);
            play_colour = 2'($urandom);
            echo_colour = 2'($urandom);
            fail_colour = 2'($urandom);
            if (!play_req && $urandom_range(0, 7) == 0) play_req = 1'b1;
            if (!fail_req && $urandom_range(0, 59) == 0) fail_req = 1'b1;
            if (!echo_req && $urandom_range(0, 9) == 0) echo_req = 1'b1;
            else if (echo_req && $urandom_range(0, 5) == 0) echo_req = 1'b0;
            tick();
            if (e_pdone && $urandom_range(0, 3) != 0) play_req = 1'b0;
            if (e_fdone && $urandom_range(0, 3) != 0) fail_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
